// File: rtl/pong_video_pkg.sv
// Shared types and constants for the pong video blocks (scheduler state, timing defaults, requester ids).
package pong_video_pkg;

    typedef enum logic [1:0] {
        ACTIVE  = 2'd0,
        IDLE    = 2'd1,
        GRANTED = 2'd2
    } sched_state_t;

    localparam int DEF_RES_W  = 10;
    localparam int DEF_YRES   = 480;
    localparam int DEF_VTOTAL = 520;

    localparam logic REQ_PHYS  = 1'b0;
    localparam logic REQ_SCORE = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: the pointed-to requester wins if it asks, otherwise the other one.
module rr_arbiter2
    import pong_video_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       last_winner,
    output logic       pick,
    output logic       pick_valid
);

    logic rr_ptr;

    // The pointer moves to the loser whenever a grant ends, normally or forced.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr <= REQ_PHYS;
        end else if (advance) begin
            rr_ptr <= ~last_winner;
        end
    end

    always_comb begin
        pick_valid = |req;
        pick       = req[rr_ptr] ? rr_ptr : ~rr_ptr;
    end

endmodule

// File: rtl/vblank_access_scheduler.sv
// Grants exclusive shared-state access to one of two requesters, only inside vertical blanking.
// Build option FRAME_SKIP_EN adds skip_div: only every (skip_div+1)-th blanking interval is eligible.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ACTIVE  | video being drawn or window closed; grant held at zero
// IDLE    | blank window open, waiting for a request outside lockout
// GRANTED | one requester owns the shared state; budget counting lines
module vblank_access_scheduler
    import pong_video_pkg::*;
#(
    parameter int RES_W           = DEF_RES_W,
    parameter int FRAME_CNT_W     = 8,
    parameter int GUARD_LINES     = 2,
    parameter int MAX_GRANT_LINES = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   line_end,
    input  logic [RES_W-1:0]       ypos,
    input  logic [RES_W-1:0]       Yresolution,
    input  logic [RES_W-1:0]       Vtotal,
    input  logic [1:0]             req,
    input  logic [1:0]             done,
`ifdef FRAME_SKIP_EN
    input  logic [3:0]             skip_div,
`endif
    output logic [1:0]             grant,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   in_blank,
    output logic                   overrun
);

    localparam int XW    = RES_W + 2;
    localparam int BUD_W = $clog2(MAX_GRANT_LINES + 1);
    localparam logic [XW-1:0]    X_ONE    = XW'(1);
    localparam logic [XW-1:0]    X_GUARD  = XW'(GUARD_LINES + 1);
    localparam logic [BUD_W-1:0] BUD_INIT = BUD_W'(MAX_GRANT_LINES);
    localparam logic [BUD_W-1:0] BUD_ONE  = BUD_W'(1);

    sched_state_t     state;
    logic             owner;
    logic [BUD_W-1:0] lines_left;
    logic             lock_q;

    logic [XW-1:0] y_x, yres_x, vt_x;
    logic          zone, fs_now, fe_now, lock_now;
    logic          rel_now, frc_now, arb_advance;
    logic          pick, pick_valid, window_ok;

    assign y_x    = {2'b00, ypos};
    assign yres_x = {2'b00, Yresolution};
    assign vt_x   = {2'b00, Vtotal};

    // Lockout describes the line that starts after this line_end: guard lines or active video.
    assign zone     = (y_x + X_GUARD >= vt_x) || (y_x + X_ONE < yres_x);
    assign fs_now   = line_end && (y_x + X_ONE == yres_x);
    assign fe_now   = line_end && (y_x + X_ONE == vt_x);
    assign lock_now = line_end ? zone : lock_q;

    assign rel_now     = done[owner] || !req[owner];
    assign frc_now     = line_end && ((lines_left == BUD_ONE) || fe_now);
    assign arb_advance = (state == GRANTED) && (rel_now || frc_now);

`ifdef FRAME_SKIP_EN
    logic [3:0] phase;

    always_ff @(posedge clock) begin
        if (!reset) begin
            phase <= 4'd0;
        end else if (fs_now) begin
            phase <= (phase >= skip_div) ? 4'd0 : phase + 4'd1;
        end
    end

    assign window_ok = (phase == 4'd0);
`else
    assign window_ok = 1'b1;
`endif

    rr_arbiter2 u_arb (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .advance     (arb_advance),
        .last_winner (owner),
        .pick        (pick),
        .pick_valid  (pick_valid)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            frame_start <= 1'b0;
            frame_count <= '0;
            in_blank    <= 1'b0;
            lock_q      <= 1'b1;
        end else begin
            frame_start <= fs_now;
            if (fs_now) begin
                frame_count <= frame_count + 1'b1;
            end
            if (line_end) begin
                in_blank <= (y_x >= yres_x);
                lock_q   <= zone;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ACTIVE;
            grant      <= 2'b00;
            owner      <= REQ_PHYS;
            lines_left <= '0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                ACTIVE: begin
                    if (fs_now && window_ok) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (lock_now) begin
                        state <= ACTIVE;
                    end else if (pick_valid) begin
                        grant      <= (pick == REQ_SCORE) ? 2'b10 : 2'b01;
                        owner      <= pick;
                        lines_left <= BUD_INIT;
                        state      <= GRANTED;
                    end
                end
                GRANTED: begin
                    // A release on the same edge as a forced revoke wins, leaving overrun alone.
                    if (rel_now) begin
                        grant <= 2'b00;
                        state <= IDLE;
                    end else if (frc_now) begin
                        grant   <= 2'b00;
                        overrun <= 1'b1;
                        state   <= fe_now ? ACTIVE : IDLE;
                    end else if (line_end) begin
                        lines_left <= lines_left - BUD_ONE;
                    end
                end
                default: begin
                    grant <= 2'b00;
                    state <= ACTIVE;
                end
            endcase
        end
    end

endmodule

// File: doc/vblank_access_scheduler.md
Name: vblank_access_scheduler

Overview:
- Arbitrates exclusive access to shared game/framebuffer state between two requesters (0 = game-physics update, 1 = score/overlay update).
- Access is granted only during vertical blanking, so no state changes while the pixel pipeline is drawing.
- Sits beside the CRT timing controller and consumes its ypos and per-line end pulse.
- Also produces a frame-start strobe and a frame counter.

Parameters:
- RES_W, 10, width of ypos/resolution/total buses
- FRAME_CNT_W, 8, width of frame counter
- GUARD_LINES, 2, blank lines before active video in which no new grant is issued
- MAX_GRANT_LINES, 16, line budget per grant before forced revoke

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- line_end  in  1  one-clock pulse at last pixel clock of each line
- ypos  in  RES_W  current line from timing generator
- Yresolution  in  RES_W  active lines (e.g. 480)
- Vtotal  in  RES_W  total lines per frame (e.g. 520)
- req  in  2  level requests; held until done
- done  in  2  one-clock release pulse from grant holder
- grant  out  2  one-hot grant or zero
- frame_start  out  1  one-clock pulse on first blank line
- frame_count  out  FRAME_CNT_W  frames completed, wraps
- in_blank  out  1  ypos >= Yresolution, registered
- overrun  out  1  sticky: a grant was force-revoked

Behaviour:
- Reset (reset==0 at clock edge):
  - grant=0, frame_start=0, frame_count=0, in_blank=0, overrun=0.
  - state=ACTIVE, rr_ptr=0 (requester 0 favoured first).
- in_blank, frame_start and the lockout compare are evaluated only on line_end pulses, using the ypos value present with the pulse, and are registered. All outputs are registered.
- frame_start:
  - pulses one clock after the line_end whose ypos == Yresolution-1.
  - frame_count increments on the same cycle and wraps to 0 after all-ones.
- lockout_zone = (ypos >= Vtotal-GUARD_LINES-1) at a line_end, or ypos < Yresolution.
- States:
  - ACTIVE: grant=0. Leave to IDLE on frame_start.
  - IDLE: if any req and not lockout:
    - winner = rr_ptr if req[rr_ptr], else the other requester.
    - next cycle grant[winner]=1, line_budget=0, go GRANTED.
    - If lockout reached with no grant, go ACTIVE.
  - GRANTED:
    - line_budget increments per line_end.
    - On done[winner] (or req[winner] dropped):
      - grant=0 next cycle, rr_ptr=~winner, go IDLE.
      - The other requester may be granted no earlier than one cycle later (one idle cycle between grants, always).
    - Force revoke when line_budget reaches MAX_GRANT_LINES, or when the line_end with ypos == Vtotal-1 arrives (active video about to begin). Force revoke:
      - grant=0 next cycle, overrun=1, rr_ptr=~winner.
      - go ACTIVE if at frame end, else IDLE.
- done when not granted, or done for the non-granted bit: ignored.
- Simultaneous done and force revoke: treated as normal release, overrun unchanged.
- overrun clears only on reset.
- Simultaneous req[0] and req[1]: rr_ptr decides; fairness over consecutive frames is guaranteed.
- Reset mid-grant: grant drops on the next edge, and no done is required.
- Vtotal <= Yresolution+GUARD_LINES: no grant is ever issued; frame_start still pulses.

Optional Feature:
- Macro: FRAME_SKIP_EN.
- Defined:
  - adds input skip_div (4 bits).
  - blank windows are open for grants only when a frame-phase counter == 0.
  - The frame-phase counter counts 0..skip_div, advances on frame_start and resets to 0.
  - Other frames stay in ACTIVE through blanking.
  - skip_div=0 behaves as every frame.
- Not defined: no port; every blanking interval is eligible.

Decomposition:
- Shared package (pong_video_pkg):
  - state enum ACTIVE/IDLE/GRANTED.
  - default timing constants (480 active, 520 total, RES_W=10).
  - requester index constants REQ_PHYS=0, REQ_SCORE=1.
- One natural sub-module: rr_arbiter2 (2-way round-robin pick from req and rr_ptr, combinational plus pointer register).
- Frame/line tracking stays in the top.

Test Plan:
- Reset low 3 cycles mid-frame with req=2'b11 -> all outputs 0; no grant until frame_start after ypos=479 line_end.
- req[0] only, done after 3 lines, at Yresolution=480 and Vtotal=520:
  - grant=01 from frame_start+1 clock.
  - grant=00 the clock after done.
  - frame_count=1.
- req=2'b11 held, done each grant after 1 line:
  - frame 1 grants 01, then 00 one cycle, then 10.
  - next frame starts with 01 (rr fairness).
- req[1] never sends done -> grant revoked after 16 line_ends, overrun=1 sticky, grant=00 through active video.
- req[0] rises on the line_end with ypos=517 (Vtotal-GUARD_LINES-1) -> no grant that frame; granted after next frame_start.
- With FRAME_SKIP_EN and skip_div=2, req[0] held -> grants only in frames 1, 4, 7; frame_count increments every frame.
